// File: rtl/regfile_write_sequencer_pkg.sv
// regfile_write_sequencer_pkg: shared widths and FSM state type for the register-bank write sequencer
package regfile_write_sequencer_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE} wseq_state_t;
endpackage

// File: rtl/regfile_write_sequencer_fifo.sv
// wseq_fifo: dual-push single-pop writeback queue exposing entry registers and valid mask
module wseq_fifo #(
  parameter int DEPTH = 4,
  parameter int AW = 5,
  parameter int DW = 32,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = IW + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_a,
  input  logic [AW-1:0]              reg_a,
  input  logic [DW-1:0]              data_a,
  input  logic                       push_b,
  input  logic [AW-1:0]              reg_b,
  input  logic [DW-1:0]              data_b,
  input  logic                       pop,
  output logic [AW-1:0]              head_reg,
  output logic [DW-1:0]              head_data,
  output logic [PW-1:0]              count,
  output logic [DEPTH-1:0][AW-1:0]   ent_reg,
  output logic [DEPTH-1:0]           ent_vld
);
  logic [PW-1:0] wptr, rptr;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [IW-1:0] wa, wb, ri;
  assign wa = wptr[IW-1:0];
  assign wb = wa + IW'(push_a);
  assign ri = rptr[IW-1:0];
  assign count = wptr - rptr;
  assign head_reg = ent_reg[ri];
  assign head_data = ent_data[ri];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        rptr <= rptr + 1'b1;
        ent_vld[ri] <= 1'b0;
      end
      if (push_a) ent_vld[wa] <= 1'b1;
      if (push_b) ent_vld[wb] <= 1'b1;
      wptr <= wptr + PW'(push_a) + PW'(push_b);
    end
  always_ff @(posedge clk) begin
    if (push_a) begin
      ent_reg[wa] <= reg_a;
      ent_data[wa] <= data_a;
    end
    if (push_b) begin
      ent_reg[wb] <= reg_b;
      ent_data[wb] <= data_b;
    end
  end
endmodule

// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer: queues ALU/load writebacks and drives the bank port as SETUP/STROBE pairs
module regfile_write_sequencer
  import regfile_write_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = REG_AW,
  parameter int DW = REG_DW,
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_reg,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_reg,
  input  logic [DW-1:0] mem_data,
  output logic          in_ready,
  input  logic [AW-1:0] rd_reg1,
  input  logic [AW-1:0] rd_reg2,
  output logic          pending1,
  output logic          pending2,
  output logic [AW-1:0] wr_reg,
  output logic [DW-1:0] wr_data,
  output logic          wr_strobe,
  output logic          idle
);
  wseq_state_t state;
  logic [AW-1:0] head_reg;
  logic [DW-1:0] head_data;
  logic [PW-1:0] count;
  logic [DEPTH-1:0][AW-1:0] ent_reg;
  logic [DEPTH-1:0] ent_vld;
  logic push_m, push_a, pop, empty, hit1, hit2;
  assign in_ready = count <= PW'(DEPTH - 2);
  assign empty = count == '0;
  // the load is the older instruction, so it takes the first slot
  assign push_m = mem_valid && in_ready && mem_reg != AW'(REG_ZERO);
  assign push_a = alu_valid && in_ready && alu_reg != AW'(REG_ZERO);
  assign pop = state != SETUP && !empty;
  assign idle = empty && state == IDLE;
  wseq_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk(clk), .rst_n(rst_n),
    .push_a(push_m), .reg_a(mem_reg), .data_a(mem_data),
    .push_b(push_a), .reg_b(alu_reg), .data_b(alu_data),
    .pop(pop), .head_reg(head_reg), .head_data(head_data), .count(count),
    .ent_reg(ent_reg), .ent_vld(ent_vld)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wr_reg <= '0;
      wr_data <= '0;
      wr_strobe <= 1'b0;
    end else if (state == SETUP) begin
      state <= STROBE;
      wr_strobe <= 1'b1;
    end else begin
      state <= empty ? IDLE : SETUP;
      wr_strobe <= 1'b0;
      if (!empty) begin
        wr_reg <= head_reg;
        wr_data <= head_data;
      end
    end
  always_comb begin
    hit1 = state != IDLE && wr_reg == rd_reg1;
    hit2 = state != IDLE && wr_reg == rd_reg2;
    for (int i = 0; i < DEPTH; i++) begin
      hit1 = hit1 || (ent_vld[i] && ent_reg[i] == rd_reg1);
      hit2 = hit2 || (ent_vld[i] && ent_reg[i] == rd_reg2);
    end
    pending1 = hit1 && rd_reg1 != AW'(REG_ZERO);
    pending2 = hit2 && rd_reg2 != AW'(REG_ZERO);
  end
endmodule
